hqm_rcfwl_gclk_iclk_qdivmon: RTL and testbench

// Receive-side checker for the hith/hitl edge-hit pulse pair produced by the

---
 rtl/hqm_rcfwl_gclk_qdivmon_pkg.sv | 28 ++
 rtl/hqm_rcfwl_gclk_iclk_qdivmon_edet.sv | 40 ++++
 rtl/hqm_rcfwl_gclk_iclk_qdivmon.sv | 200 ++++++++++++++++++++
 tb/tb_hqm_rcfwl_gclk_iclk_qdivmon.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hqm_rcfwl_gclk_qdivmon_pkg.sv
// Shared types and helpers for the iclk quadrature divider monitor.
// Holds the FSM encoding, the minimum legal ratio and the hitl offset rule.
package hqm_rcfwl_gclk_qdivmon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ERR    = 2'd3
    } qdivmon_state_t;

    localparam logic [3:0] RATIO_MIN = 4'd2;

    // Odd ratios in 50% mode time hitl from the falling edge,
    // which lands one clkin posedge later.
    function automatic logic [3:0] exp_offset(
        input logic [3:0] ratiom3,
        input logic       dutycyc_50p_en
    );
        logic [3:0] h;
        h = ratiom3 >> 1;
        if (ratiom3[0] & dutycyc_50p_en) begin
            return h + 4'd1;
        end
        return h;
    endfunction

endpackage

// File: rtl/hqm_rcfwl_gclk_iclk_qdivmon_edet.sv
// Input sync register, rise detector and saturating interval counter.
// The counter restarts at 1 on a rise or an external restart request.
module hqm_rcfwl_gclk_iclk_qdivmon_edet
    import hqm_rcfwl_gclk_qdivmon_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clkin,
    input  logic             divrstb,
    input  logic             din,
    input  logic             clr,
    input  logic             restart,
    output logic             rise,
    output logic [CNT_W-1:0] cnt
);

    logic cur;
    logic prev;

    assign rise = cur & ~prev;

    always_ff @(posedge clkin or negedge divrstb) begin
        if (!divrstb) begin
            cur  <= 1'b0;
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            cur  <= din;
            prev <= cur;
            if (clr) begin
                cnt <= '0;
            end else if (rise || restart) begin
                cnt <= CNT_W'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hqm_rcfwl_gclk_iclk_qdivmon.sv
// Checker for the hith/hitl pulse pair of the iclk quadrature divider.
// Tracks lock, sticky period/phase errors and a saturating error count.
module hqm_rcfwl_gclk_iclk_qdivmon
    import hqm_rcfwl_gclk_qdivmon_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 5,
    parameter int ERRC_W   = 8
) (
    input  logic              clkin,
    input  logic              divrstb,
    input  logic              hith,
    input  logic              hitl,
    input  logic [3:0]        ratiom3,
    input  logic              dutycyc_50p_en,
    input  logic              mon_en,
    input  logic              clr_err,
    output logic              locked,
    output logic              err_period,
    output logic              err_phase,
    output logic [1:0]        mon_state,
    output logic [CNT_W-1:0]  meas_period,
    output logic [ERRC_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_M1 = 4'(LOCK_CNT - 1);

    qdivmon_state_t    state;
    logic [3:0]        ratio_q;
    logic [3:0]        good_cnt;
    logic              meas_open;
    logic              hl_seen;
    logic              hl_bad;
    logic              hl_cur;
    logic              hl_prev;
    logic              hith_rise;
    logic              hitl_rise;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  p_ext;
    logic [CNT_W-1:0]  p2_ext;
    logic [CNT_W-1:0]  eo_ext;
    logic              hl_hit;
    logic              hl_seen_n;
    logic              hl_bad_n;
    logic              close;
    logic              tmo;
    logic              per_bad;
    logic              ph_bad;
    logic              bad;
    logic              good;
    logic              ratio_ok;
    logic              ratio_chg;
    logic [ERRC_W-1:0] err_base;

    assign cnt_clr = (state == ST_IDLE);

    hqm_rcfwl_gclk_iclk_qdivmon_edet #(
        .CNT_W (CNT_W)
    ) u_hith_edet (
        .clkin   (clkin),
        .divrstb (divrstb),
        .din     (hith),
        .clr     (cnt_clr),
        .restart (tmo),
        .rise    (hith_rise),
        .cnt     (cnt)
    );

    // hitl only needs its rise; its offset is read off the hith counter.
    always_ff @(posedge clkin or negedge divrstb) begin
        if (!divrstb) begin
            hl_cur  <= 1'b0;
            hl_prev <= 1'b0;
        end else begin
            hl_cur  <= hitl;
            hl_prev <= hl_cur;
        end
    end

    assign hitl_rise = hl_cur & ~hl_prev;

    assign p_ext  = CNT_W'(ratio_q);
    assign p2_ext = CNT_W'({ratio_q, 1'b0});
    assign eo_ext = CNT_W'(exp_offset(ratio_q, dutycyc_50p_en));

    assign ratio_ok  = (ratio_q >= RATIO_MIN);
    assign ratio_chg = (ratiom3 != ratio_q);

    // A hitl rise on the closing hith edge belongs to the closing period.
    assign hl_hit    = meas_open & hitl_rise;
    assign hl_seen_n = hl_seen | hl_hit;
    assign hl_bad_n  = hl_bad
                     | (hl_hit & (hl_seen | (cnt != eo_ext)));

    assign close   = meas_open & hith_rise;
    assign tmo     = meas_open & ~hith_rise & (cnt >= p2_ext);
    assign per_bad = (close & (cnt != p_ext)) | tmo;
    assign ph_bad  = close & ~(hl_seen_n & ~hl_bad_n);
    assign bad     = per_bad | ph_bad;
    assign good    = close & ~bad;

    assign err_base = clr_err ? '0 : err_cnt;

    always_ff @(posedge clkin or negedge divrstb) begin
        if (!divrstb) begin
            state       <= ST_IDLE;
            ratio_q     <= '0;
            good_cnt    <= '0;
            meas_open   <= 1'b0;
            hl_seen     <= 1'b0;
            hl_bad      <= 1'b0;
            err_period  <= 1'b0;
            err_phase   <= 1'b0;
            err_cnt     <= '0;
            meas_period <= '0;
        end else begin
            ratio_q <= ratiom3;
            if (close) begin
                meas_period <= cnt;
            end
            if (close || tmo) begin
                hl_seen <= 1'b0;
                hl_bad  <= 1'b0;
            end else if (hl_hit) begin
                hl_seen <= 1'b1;
                hl_bad  <= hl_bad_n;
            end
            if (clr_err) begin
                err_period <= 1'b0;
                err_phase  <= 1'b0;
                err_cnt    <= '0;
            end
            if (!mon_en) begin
                state     <= ST_IDLE;
                good_cnt  <= '0;
                meas_open <= 1'b0;
                hl_seen   <= 1'b0;
                hl_bad    <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (ratio_ok) begin
                            state <= ST_ACQ;
                        end
                    end
                    ST_ACQ, ST_LOCKED: begin
                        if (!ratio_ok) begin
                            state     <= ST_IDLE;
                            good_cnt  <= '0;
                            meas_open <= 1'b0;
                            hl_seen   <= 1'b0;
                            hl_bad    <= 1'b0;
                        end else if (ratio_chg) begin
                            state     <= ST_ACQ;
                            good_cnt  <= '0;
                            meas_open <= 1'b0;
                            hl_seen   <= 1'b0;
                            hl_bad    <= 1'b0;
                        end else if (state == ST_ACQ) begin
                            if (!meas_open) begin
                                meas_open <= hith_rise;
                            end else if (bad) begin
                                good_cnt <= '0;
                            end else if (good) begin
                                good_cnt <= good_cnt + 4'd1;
                                if (good_cnt == LOCK_M1) begin
                                    state <= ST_LOCKED;
                                end
                            end
                        end else if (bad) begin
                            // A new error outranks a same-cycle clear.
                            state      <= ST_ERR;
                            err_period <= (err_period & ~clr_err)
                                        | per_bad;
                            err_phase  <= (err_phase & ~clr_err)
                                        | ph_bad;
                            err_cnt    <= (err_base == '1) ? err_base
                                        : err_base + ERRC_W'(1);
                        end
                    end
                    ST_ERR: begin
                        if (clr_err) begin
                            state     <= ST_ACQ;
                            good_cnt  <= '0;
                            meas_open <= 1'b0;
                            hl_seen   <= 1'b0;
                            hl_bad    <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign locked    = (state == ST_LOCKED);
    assign mon_state = state;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_iclk_qdivmon.sv
// Random and directed stimulus for the quadrature divider monitor.
// Expected outputs come from a timestamp-based model of the checking rules.
module tb_hqm_rcfwl_gclk_iclk_qdivmon;

    localparam int LOCK_CNT = 4;
    localparam int CNT_W    = 5;
    localparam int ERRC_W   = 8;

    logic              clkin = 1'b0;
    logic              divrstb = 1'b1;
    logic              hith = 1'b0;
    logic              hitl = 1'b0;
    logic [3:0]        ratiom3 = 4'd0;
    logic              dutycyc_50p_en = 1'b0;
    logic              mon_en = 1'b0;
    logic              clr_err = 1'b0;
    logic              locked;
    logic              err_period;
    logic              err_phase;
    logic [1:0]        mon_state;
    logic [CNT_W-1:0]  meas_period;
    logic [ERRC_W-1:0] err_cnt;

    int total = 0;
    int bad = 0;

    always #5 clkin = ~clkin;

    hqm_rcfwl_gclk_iclk_qdivmon #(
        .LOCK_CNT (LOCK_CNT),
        .CNT_W    (CNT_W),
        .ERRC_W   (ERRC_W)
    ) dut (
        .clkin          (clkin),
        .divrstb        (divrstb),
        .hith           (hith),
        .hitl           (hitl),
        .ratiom3        (ratiom3),
        .dutycyc_50p_en (dutycyc_50p_en),
        .mon_en         (mon_en),
        .clr_err        (clr_err),
        .locked         (locked),
        .err_period     (err_period),
        .err_phase      (err_phase),
        .mon_state      (mon_state),
        .meas_period    (meas_period),
        .err_cnt        (err_cnt)
    );

    task automatic chk(input string tag, input int obs,
                       input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            if (bad <= 40) begin
                $display("FAIL %s got=%0d want=%0d t=%0t",
                         tag, obs, exp, $time);
            end
        end
    endtask

    // Stream generator: hith pulse every gp cycles, hitl at +go.
    int gp = 4;
    int go = 2;
    int gpos = 0;
    int stall = 0;
    int mute_h = 0;
    int mute_l = 0;

    task automatic gen_drive();
        hith = (gpos == 0) && (mute_h == 0);
        hitl = (gpos == go) && (mute_l == 0);
        if (mute_h > 0) mute_h--;
        if (mute_l > 0) mute_l--;
        if (stall > 0 && gpos == gp - 1) begin
            stall--;
        end else begin
            gpos = (gpos + 1) % gp;
        end
    endtask

    // Model: time-stamped hith boundaries and a list of hitl offsets.
    int m_st, m_good, m_open, m_t, m_ts, m_per;
    int m_eper, m_eph, m_ecnt, m_rq;
    bit m_h1, m_h2, m_l1, m_l2;
    int m_offs[$];

    task automatic model_reset();
        m_st = 0; m_good = 0; m_open = 0; m_t = 0; m_ts = 0;
        m_per = 0; m_eper = 0; m_eph = 0; m_ecnt = 0; m_rq = 0;
        m_h1 = 0; m_h2 = 0; m_l1 = 0; m_l2 = 0;
        m_offs.delete();
    endtask

    task automatic model_step();
        int p, eo, el;
        bit rh, rl, cl, to, pb, qb, bd, gd, chg;
        rh = m_h1 && !m_h2;
        rl = m_l1 && !m_l2;
        p  = m_rq;
        eo = p / 2 + ((p % 2 == 1 && dutycyc_50p_en) ? 1 : 0);
        el = m_t - m_ts;
        cl = m_open != 0 && rh;
        to = m_open != 0 && !rh && el >= 2 * p;
        if (m_open != 0 && rl && !to) m_offs.push_back(el);
        pb = (cl && el != p) || to;
        qb = cl && !(m_offs.size() == 1 && m_offs[0] == eo);
        bd = pb || qb;
        gd = cl && !bd;
        if (cl) m_per = el;
        if (cl || to) begin
            m_ts = m_t;
            m_offs.delete();
        end
        chg = int'(ratiom3) != m_rq;
        if (clr_err) begin
            m_eper = 0; m_eph = 0; m_ecnt = 0;
        end
        if (!mon_en) begin
            m_st = 0; m_good = 0; m_open = 0;
            m_offs.delete();
        end else begin
            case (m_st)
                0: if (p >= 2) m_st = 1;
                1, 2: begin
                    if (p < 2) begin
                        m_st = 0; m_good = 0; m_open = 0;
                    end else if (chg) begin
                        m_st = 1; m_good = 0; m_open = 0;
                    end else if (m_st == 1) begin
                        if (m_open == 0) begin
                            if (rh) begin
                                m_open = 1;
                                m_ts = m_t;
                                m_offs.delete();
                            end
                        end else if (bd) begin
                            m_good = 0;
                        end else if (gd) begin
                            m_good++;
                            if (m_good == LOCK_CNT) m_st = 2;
                        end
                    end else if (bd) begin
                        m_st = 3;
                        if (pb) m_eper = 1;
                        if (qb) m_eph = 1;
                        if (m_ecnt < 255) m_ecnt++;
                    end
                end
                default: begin
                    if (clr_err) begin
                        m_st = 1; m_good = 0; m_open = 0;
                    end
                end
            endcase
        end
        m_h2 = m_h1; m_h1 = hith;
        m_l2 = m_l1; m_l1 = hitl;
        m_rq = int'(ratiom3);
        m_t++;
    endtask

    task automatic check_all();
        chk("locked", int'(locked), (m_st == 2) ? 1 : 0);
        chk("err_period", int'(err_period), m_eper);
        chk("err_phase", int'(err_phase), m_eph);
        chk("mon_state", int'(mon_state), m_st);
        chk("meas_period", int'(meas_period), m_per);
        chk("err_cnt", int'(err_cnt), m_ecnt);
    endtask

    task automatic cyc();
        gen_drive();
        @(posedge clkin);
        model_step();
        @(negedge clkin);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
    endtask

    task automatic set_stream(input int r, input int off);
        ratiom3 = 4'(r);
        gp = r;
        go = off;
        gpos = 0;
    endtask

    task automatic reset_pulse(input string tag);
        #1 divrstb = 1'b0;
        #1;
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_eper"}, int'(err_period), 0);
        chk({tag, "_eph"}, int'(err_phase), 0);
        chk({tag, "_state"}, int'(mon_state), 0);
        chk({tag, "_meas"}, int'(meas_period), 0);
        chk({tag, "_ecnt"}, int'(err_cnt), 0);
        model_reset();
        @(negedge clkin);
        divrstb = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clkin);
        reset_pulse("por");

        // Ratio 4, hitl at +2: locks, measures 4.
        mon_en = 1'b1;
        set_stream(4, 2);
        run(40);
        chk("s1_locked", int'(locked), 1);
        chk("s1_meas", int'(meas_period), 4);
        chk("s1_flags", int'({err_period, err_phase}), 0);

        // Ratio 5 in 50% mode expects hitl at +3.
        dutycyc_50p_en = 1'b1;
        set_stream(5, 3);
        run(60);
        chk("s2_locked", int'(locked), 1);
        chk("s2_meas", int'(meas_period), 5);
        mon_en = 1'b0;
        cyc();
        pulse_clr();
        dutycyc_50p_en = 1'b0;
        mon_en = 1'b1;
        run(60);
        chk("s2_nolock", int'(locked), 0);
        chk("s2_acq", int'(mon_state), 1);
        chk("s2_flags", int'({err_period, err_phase}), 0);

        // One stretched period while locked.
        set_stream(4, 2);
        pulse_clr();
        run(40);
        chk("s3_locked", int'(locked), 1);
        stall = 1;
        run(12);
        chk("s3_eper", int'(err_period), 1);
        chk("s3_eph", int'(err_phase), 0);
        chk("s3_ecnt", int'(err_cnt), 1);
        chk("s3_unlock", int'(locked), 0);
        chk("s3_err", int'(mon_state), 3);
        pulse_clr();
        run(40);
        chk("s3_relock", int'(mon_state), 2);

        // hith timeout, then a missing hitl.
        set_stream(6, 3);
        run(60);
        chk("s4_locked", int'(locked), 1);
        mute_h = 16;
        run(20);
        chk("s4_tmo_eper", int'(err_period), 1);
        chk("s4_tmo_eph", int'(err_phase), 0);
        chk("s4_tmo_ecnt", int'(err_cnt), 1);
        pulse_clr();
        run(60);
        chk("s4_relock", int'(locked), 1);
        mute_l = 6;
        run(20);
        chk("s4_miss_eph", int'(err_phase), 1);
        chk("s4_miss_eper", int'(err_period), 0);
        chk("s4_miss_st", int'(mon_state), 3);

        // Ratio change re-acquires silently; ratio 1 is illegal.
        pulse_clr();
        set_stream(4, 2);
        run(40);
        chk("s5_locked4", int'(locked), 1);
        set_stream(8, 4);
        cyc();
        cyc();
        chk("s5_acq", int'(mon_state), 1);
        run(80);
        chk("s5_locked8", int'(locked), 1);
        chk("s5_meas8", int'(meas_period), 8);
        chk("s5_flags", int'({err_period, err_phase}), 0);
        ratiom3 = 4'd1;
        run(4);
        chk("s5_idle", int'(mon_state), 0);

        // Async reset while locked; mon_en drop in ERR.
        set_stream(4, 2);
        run(40);
        chk("s6_locked", int'(locked), 1);
        reset_pulse("s6_rst");
        run(40);
        chk("s6_relock", int'(locked), 1);
        stall = 1;
        run(12);
        chk("s6_err", int'(mon_state), 3);
        mon_en = 1'b0;
        cyc();
        chk("s6_idle", int'(mon_state), 0);
        chk("s6_keep_eper", int'(err_period), 1);
        chk("s6_keep_ecnt", int'(err_cnt), 1);
        mon_en = 1'b1;

        // Random segments with glitches, clears and enable drops.
        for (int s = 0; s < 24; s++) begin
            int r, n, k;
            r = $urandom_range(2, 15);
            dutycyc_50p_en = 1'($urandom_range(0, 1));
            k = (r / 2)
              + ((r % 2 == 1 && dutycyc_50p_en) ? 1 : 0);
            ratiom3 = 4'(r);
            gp = ($urandom_range(0, 4) == 0)
               ? ((r > 2) ? r - 1 : r + 1) : r;
            go = ($urandom_range(0, 4) == 0)
               ? $urandom_range(1, gp - 1) : k;
            gpos = 0;
            if (s == 12) reset_pulse("rnd_rst");
            n = $urandom_range(40, 90);
            for (int c = 0; c < n; c++) begin
                k = $urandom_range(0, 99);
                if (k < 2) clr_err = 1'b1;
                if (k == 2) mute_h = $urandom_range(1, 20);
                if (k == 3) mute_l = gp;
                if (k == 4) stall = 1;
                if (k == 5) mon_en = 1'b0;
                cyc();
                clr_err = 1'b0;
                mon_en = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
